// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: per-FU writeback FIFOs drained round-robin, one result per cycle, onto a registered CDB.
// Latency: FU result at t reaches the CDB at t+2 when uncontended (t+1 via the empty-FIFO bypass when FU_WB_ARB_BYPASS_EN is defined).
// Backpressure: FU ports cannot stall; fu_stall throttles issue early, and a push into a full, un-popped FIFO is dropped and sets sticky fu_overflow.
module fu_wb_arbiter #(
   parameter int  NUM_FU       = 4,
   parameter int  FIFO_DEPTH   = 4,
   parameter int  STALL_SLACK  = 2,
   parameter int  INST_ID_BITS = 6,
   parameter int  PRN_BITS     = 6,
   parameter int  MAX_OPERANDS = 3,
   localparam int IDX_W        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    fu_out_valid      [NUM_FU],
   input  logic [INST_ID_BITS-1:0] fu_out_inst_id    [NUM_FU],
   input  logic [PRN_BITS-1:0]     fu_out_prn        [NUM_FU][MAX_OPERANDS],
   input  logic [63:0]             fu_out_data       [NUM_FU][MAX_OPERANDS],
   input  logic                    fu_out_data_valid [NUM_FU][MAX_OPERANDS],
   output logic                    fu_stall          [NUM_FU],
   output logic                    fu_overflow       [NUM_FU],
   output logic                    cdb_valid,
   output logic [INST_ID_BITS-1:0] cdb_inst_id,
   output logic [PRN_BITS-1:0]     cdb_prn           [MAX_OPERANDS],
   output logic [63:0]             cdb_data          [MAX_OPERANDS],
   output logic                    cdb_data_valid    [MAX_OPERANDS],
   output logic [IDX_W-1:0]        cdb_fu_idx
);

   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int STALL_LVL = FIFO_DEPTH - STALL_SLACK;

   typedef struct packed {
      logic [INST_ID_BITS-1:0]               inst_id;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
      logic [MAX_OPERANDS-1:0][63:0]         data;
      logic [MAX_OPERANDS-1:0]               dv;
   } pkt_t;

   pkt_t             in_pkt  [NUM_FU];
   pkt_t             mem     [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr  [NUM_FU];
   logic [PTR_W-1:0] wr_ptr  [NUM_FU];
   logic [CNT_W-1:0] count   [NUM_FU];
   logic             cand    [NUM_FU];
   logic             pop     [NUM_FU];
   logic             byp     [NUM_FU];
   logic             push    [NUM_FU];
   logic             drop    [NUM_FU];
   logic [IDX_W-1:0] last_grant;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   pkt_t             gnt_pkt;
   pkt_t             cdb_pkt;

   // Gather each FU's live result ports into one packet; stall is a pure function of occupancy
   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign in_pkt[i].inst_id = fu_out_inst_id[i];
      for (genvar s = 0; s < MAX_OPERANDS; s++) begin : g_slot
         assign in_pkt[i].prn[s]  = fu_out_prn[i][s];
         assign in_pkt[i].data[s] = fu_out_data[i][s];
         assign in_pkt[i].dv[s]   = fu_out_data_valid[i][s];
      end
      assign fu_stall[i] = (count[i] >= CNT_W'(STALL_LVL));
   end

   // Candidate set: non-empty FIFOs, plus empty FIFOs with a live result when bypass is built in
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         cand[i] = (count[i] != '0);
`ifdef FU_WB_ARB_BYPASS_EN
         cand[i] = cand[i] | fu_out_valid[i];
`endif
      end
   end

   // Round-robin pick: first candidate above last_grant, otherwise first candidate from index 0
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (!gnt_vld && cand[i] && (i > int'(last_grant))) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (!gnt_vld && cand[i] && (i <= int'(last_grant))) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
   end

   // Source the granted packet (FIFO head, or live inputs on a bypass) and decide push/drop per FU
   always_comb begin
      gnt_pkt = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         pop[i] = 1'b0;
         byp[i] = 1'b0;
         if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
            if (count[i] != '0) begin
               gnt_pkt = mem[i][rd_ptr[i]];
               pop[i]  = 1'b1;
            end else begin
               gnt_pkt = in_pkt[i];
               byp[i]  = 1'b1;
            end
         end
         // a full FIFO still accepts when its head leaves in the same cycle
         push[i] = fu_out_valid[i] && !byp[i] && ((count[i] < CNT_W'(FIFO_DEPTH)) || pop[i]);
         drop[i] = fu_out_valid[i] && !byp[i] && !push[i];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flags; flush empties everything like reset
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < NUM_FU; i++) begin
            rd_ptr[i]      <= '0;
            wr_ptr[i]      <= '0;
            count[i]       <= '0;
            fu_overflow[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            if (drop[i]) fu_overflow[i] <= 1'b1;
         end
      end
   end

   // FIFO storage; stale writes during reset/flush are harmless because the pointers restart
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= in_pkt[i];
      end
   end

   // CDB register and round-robin pointer; flush kills the next beat but keeps last_grant
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= IDX_W'(NUM_FU - 1);
         cdb_valid  <= 1'b0;
         cdb_pkt    <= '0;
         cdb_fu_idx <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else begin
         cdb_valid <= gnt_vld;
         if (gnt_vld) begin
            last_grant <= gnt_idx;
            cdb_pkt    <= gnt_pkt;
            cdb_fu_idx <= gnt_idx;
         end
      end
   end

   // CDB outputs are straight wiring from the registered packet
   assign cdb_inst_id = cdb_pkt.inst_id;
   for (genvar s = 0; s < MAX_OPERANDS; s++) begin : g_cdb
      assign cdb_prn[s]        = cdb_pkt.prn[s];
      assign cdb_data[s]       = cdb_pkt.data[s];
      assign cdb_data_valid[s] = cdb_pkt.dv[s];
   end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb_fu_wb_arbiter: directed and randomized stimulus for fu_wb_arbiter against a queue-level reference model.
// Latency: model predicts the CDB beat and flags registered at each clock edge; compared on the following falling edge.
// Backpressure: stimulus ignores fu_stall on purpose so overflow drops are exercised.
module tb_fu_wb_arbiter;
   localparam int NUM_FU = 4;
   localparam int DEPTH  = 4;
   localparam int SLACK  = 2;
   localparam int NOP    = 3;
`ifdef FU_WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int STALL_EDGE = BYP ? 2 : 1;
   localparam int OVF_EDGE   = BYP ? 6 : 5;

   typedef struct packed {
      logic [5:0]        id;
      logic [2:0][5:0]   prn;
      logic [2:0][63:0]  data;
      logic [2:0]        dv;
   } pkt_t;

   logic        clk, rst, flush;
   logic        fu_out_valid      [NUM_FU];
   logic [5:0]  fu_out_inst_id    [NUM_FU];
   logic [5:0]  fu_out_prn        [NUM_FU][NOP];
   logic [63:0] fu_out_data       [NUM_FU][NOP];
   logic        fu_out_data_valid [NUM_FU][NOP];
   logic        fu_stall          [NUM_FU];
   logic        fu_overflow       [NUM_FU];
   logic        cdb_valid;
   logic [5:0]  cdb_inst_id;
   logic [5:0]  cdb_prn           [NOP];
   logic [63:0] cdb_data          [NOP];
   logic        cdb_data_valid    [NOP];
   logic [1:0]  cdb_fu_idx;

   fu_wb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(DEPTH), .STALL_SLACK(SLACK),
                   .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(NOP)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fu_out_valid(fu_out_valid), .fu_out_inst_id(fu_out_inst_id), .fu_out_prn(fu_out_prn),
      .fu_out_data(fu_out_data), .fu_out_data_valid(fu_out_data_valid),
      .fu_stall(fu_stall), .fu_overflow(fu_overflow),
      .cdb_valid(cdb_valid), .cdb_inst_id(cdb_inst_id), .cdb_prn(cdb_prn),
      .cdb_data(cdb_data), .cdb_data_valid(cdb_data_valid), .cdb_fu_idx(cdb_fu_idx));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic pkt_t live_pkt(input int i);
      pkt_t p;
      p.id = fu_out_inst_id[i];
      for (int s = 0; s < NOP; s++) begin
         p.prn[s]  = fu_out_prn[i][s];
         p.data[s] = fu_out_data[i][s];
         p.dv[s]   = fu_out_data_valid[i][s];
      end
      return p;
   endfunction

   function automatic pkt_t dut_pkt();
      pkt_t p;
      p.id = cdb_inst_id;
      for (int s = 0; s < NOP; s++) begin
         p.prn[s]  = cdb_prn[s];
         p.data[s] = cdb_data[s];
         p.dv[s]   = cdb_data_valid[s];
      end
      return p;
   endfunction

   function automatic logic [NUM_FU-1:0] stall_vec();
      logic [NUM_FU-1:0] v;
      for (int i = 0; i < NUM_FU; i++) v[i] = fu_stall[i];
      return v;
   endfunction

   function automatic logic [NUM_FU-1:0] ovf_vec();
      logic [NUM_FU-1:0] v;
      for (int i = 0; i < NUM_FU; i++) v[i] = fu_overflow[i];
      return v;
   endfunction

   // ---------------- reference model: plain queues, one step per rising edge
   pkt_t              mq [NUM_FU][$];
   int                m_lg;
   bit                m_v;
   pkt_t              m_pkt;
   int                m_idx;
   logic [NUM_FU-1:0] m_ovf;
   int                m_g, m_byp, m_c;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FU; i++) mq[i].delete();
         m_lg = NUM_FU - 1; m_v = 1'b0; m_pkt = '0; m_idx = 0; m_ovf = '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_FU; i++) mq[i].delete();
         m_v = 1'b0; m_ovf = '0;
      end else begin
         m_g = -1; m_byp = -1;
         for (int k = 1; k <= NUM_FU; k++) begin
            m_c = (m_lg + k) % NUM_FU;
            if (m_g < 0 && (mq[m_c].size() > 0 || (BYP && fu_out_valid[m_c]))) m_g = m_c;
         end
         m_v = (m_g >= 0);
         if (m_v) begin
            m_lg = m_g; m_idx = m_g;
            if (mq[m_g].size() > 0) m_pkt = mq[m_g].pop_front();
            else begin m_pkt = live_pkt(m_g); m_byp = m_g; end
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_out_valid[i] && i != m_byp) begin
               if (mq[i].size() < DEPTH) mq[i].push_back(live_pkt(i));
               else m_ovf[i] = 1'b1;
            end
         end
      end
   end

   // ---------------- compare process plus beat logging for directed checks
   logic [63:0] forbid;
   int          forbid_hits = 0;
   bit          watch40 = 0;
   int          seen40 = 0;
   bit          log_on = 0;
   int          beat_id[$], beat_fu[$], beat_cyc[$];
   int          cyc_n = 0;
   logic [NUM_FU-1:0] exp_st;

   always @(negedge clk) begin
      cyc_n++;
      chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
      if (m_v) begin
         n_assert++;
         if (dut_pkt() !== m_pkt || cdb_fu_idx !== 2'(m_idx)) begin
            n_fail++;
            $display("FAIL cdb_beat: got id=%0d fu=%0d d0=%0h dv=%b, expected id=%0d fu=%0d d0=%0h dv=%b",
                     cdb_inst_id, cdb_fu_idx, cdb_data[0], dut_pkt().dv, m_pkt.id, m_idx, m_pkt.data[0], m_pkt.dv);
         end
      end
      for (int i = 0; i < NUM_FU; i++) exp_st[i] = (mq[i].size() >= DEPTH - SLACK);
      chk("fu_stall", 64'(stall_vec()), 64'(exp_st));
      chk("fu_overflow", 64'(ovf_vec()), 64'(m_ovf));
      if (cdb_valid === 1'b1) begin
         if (forbid[cdb_inst_id]) forbid_hits++;
         if (watch40 && cdb_inst_id == 6'd40 && cdb_fu_idx == 2'd3) seen40++;
         if (log_on) begin
            beat_id.push_back(int'(cdb_inst_id));
            beat_fu.push_back(int'(cdb_fu_idx));
            beat_cyc.push_back(cyc_n);
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_fu(input int i, input logic [5:0] id);
      fu_out_valid[i]   = 1'b1;
      fu_out_inst_id[i] = id;
      for (int s = 0; s < NOP; s++) begin
         fu_out_prn[i][s]        = 6'($urandom);
         fu_out_data[i][s]       = {$urandom, $urandom};
         fu_out_data_valid[i][s] = 1'($urandom);
      end
   endtask

   task automatic idle();
      for (int i = 0; i < NUM_FU; i++) fu_out_valid[i] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc(1); rst = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
      chk({tag, "_cdb_payload_nonzero"}, 64'(dut_pkt() !== pkt_t'(0)), 64'd0);
      chk({tag, "_cdb_fu_idx"}, 64'(cdb_fu_idx), 64'd0);
      chk({tag, "_fu_stall"}, 64'(stall_vec()), 64'd0);
      chk({tag, "_fu_overflow"}, 64'(ovf_vec()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; forbid = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_out_valid[i] = 1'b0; fu_out_inst_id[i] = '0;
         for (int s = 0; s < NOP; s++) begin
            fu_out_prn[i][s] = '0; fu_out_data[i][s] = '0; fu_out_data_valid[i][s] = 1'b0;
         end
      end
      cyc(3);
      chk_reset_values("reset");
      rst = 1'b0;

      // single result from FU2, fixed payload
      fu_out_valid[2] = 1'b1; fu_out_inst_id[2] = 6'd5;
      fu_out_prn[2][0] = 6'd3; fu_out_prn[2][1] = 6'd7; fu_out_prn[2][2] = 6'd9;
      fu_out_data[2][0] = 64'hA; fu_out_data[2][1] = 64'hB; fu_out_data[2][2] = 64'hC;
      fu_out_data_valid[2][0] = 1'b1; fu_out_data_valid[2][1] = 1'b0; fu_out_data_valid[2][2] = 1'b1;
      cyc(1);
      idle();
      if (!BYP) cyc(1);
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_id", 64'(cdb_inst_id), 64'd5);
      chk("single_prn0", 64'(cdb_prn[0]), 64'd3);
      chk("single_prn1", 64'(cdb_prn[1]), 64'd7);
      chk("single_prn2", 64'(cdb_prn[2]), 64'd9);
      chk("single_data0", cdb_data[0], 64'hA);
      chk("single_data1", cdb_data[1], 64'hB);
      chk("single_data2", cdb_data[2], 64'hC);
      chk("single_dv", {61'd0, cdb_data_valid[2], cdb_data_valid[1], cdb_data_valid[0]}, 64'b101);
      chk("single_fu_idx", 64'(cdb_fu_idx), 64'd2);
      cyc(1);
      chk("single_one_beat", 64'(cdb_valid), 64'd0);

      // round-robin: two back-to-back batches after reset
      do_reset();
      beat_id.delete(); beat_fu.delete(); beat_cyc.delete(); log_on = 1'b1;
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(10 + i));
      cyc(1);
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(14 + i));
      cyc(1);
      idle();
      cyc(12);
      log_on = 1'b0;
      chk("rr_beats", 64'(beat_id.size()), 64'd8);
      for (int k = 0; k < 8 && k < beat_id.size(); k++) begin
         chk("rr_order_id", 64'(beat_id[k]), 64'(10 + k));
         chk("rr_order_fu", 64'(beat_fu[k]), 64'(k % NUM_FU));
         chk("rr_consecutive", 64'(beat_cyc[k] - beat_cyc[0]), 64'(k));
      end

      // stall and overflow: all FUs push every cycle, FU1 falls behind
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(i * 16 + k));
         cyc(1);
         if (k == STALL_EDGE - 1) chk("stall1_low", 64'(fu_stall[1]), 64'd0);
         if (k == STALL_EDGE)     chk("stall1_high", 64'(fu_stall[1]), 64'd1);
         if (k == OVF_EDGE - 1)   chk("ovf1_low", 64'(fu_overflow[1]), 64'd0);
         if (k == OVF_EDGE) begin
            chk("ovf1_high", 64'(fu_overflow[1]), 64'd1);
            forbid[16 + OVF_EDGE] = 1'b1;
         end
      end
      idle();
      cyc(24);
      chk("ovf1_sticky", 64'(fu_overflow[1]), 64'd1);
      chk("dropped_id_absent", 64'(forbid_hits), 64'd0);
      flush = 1'b1; cyc(1); flush = 1'b0;
      chk("flush_clears_ovf", 64'(ovf_vec()), 64'd0);
      forbid = '0;

      // full FIFO3 granted while FU3 pushes ID 40
      do_reset();
      watch40 = 1'b1; seen40 = 0;
      for (int i = 0; i < 3; i++) set_fu(i, 6'(1 + i));
      set_fu(3, 6'd30);
      cyc(1);
      idle();
      for (int k = 1; k < 4; k++) begin set_fu(3, 6'(30 + k)); cyc(1); end
      set_fu(3, 6'd40);
      cyc(1);
      idle();
      chk("full_pushpop_no_ovf", 64'(fu_overflow[3]), 64'd0);
      cyc(12);
      chk("id40_delivered_once", 64'(seen40), 64'd1);
      watch40 = 1'b0;

      // flush with three FIFOs loaded and results presented in the flush cycle
      do_reset();
      for (int i = 0; i < 3; i++) for (int k = 1; k < 4; k++) forbid[48 + i * 4 + k] = 1'b1;
      forbid_hits = 0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 3; i++) set_fu(i, 6'(48 + i * 4 + k));
         if (k == 3) flush = 1'b1;
         cyc(1);
      end
      flush = 1'b0; idle();
      chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("flush_stall", 64'(stall_vec()), 64'd0);
      chk("flush_ovf", 64'(ovf_vec()), 64'd0);
      cyc(12);
      chk("flushed_ids_absent", 64'(forbid_hits), 64'd0);
      forbid = '0;

      // reset in the middle of traffic
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < NUM_FU; i++)
            if ($urandom_range(3, 0) != 0) set_fu(i, 6'($urandom_range(59, 0))); else fu_out_valid[i] = 1'b0;
         cyc(1);
      end
      rst = 1'b1; cyc(1); rst = 1'b0;
      chk_reset_values("midrst");
      beat_id.delete(); beat_fu.delete(); beat_cyc.delete(); log_on = 1'b1;
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(60 + i));
      cyc(1);
      idle();
      cyc(8);
      log_on = 1'b0;
      chk("midrst_beats", 64'(beat_id.size()), 64'd4);
      if (beat_id.size() > 0) begin
         chk("midrst_first_fu", 64'(beat_fu[0]), 64'd0);
         chk("midrst_first_id", 64'(beat_id[0]), 64'd60);
      end

      // randomized traffic with varying load, occasional flush and reset
      for (int c = 0; c < 3000; c++) begin
         int load;
         load = (c / 250) % 4;
         for (int i = 0; i < NUM_FU; i++)
            if ($urandom_range(7, 0) < 2 * load + 1) set_fu(i, 6'($urandom)); else fu_out_valid[i] = 1'b0;
         flush = ($urandom_range(99, 0) == 0);
         rst   = ($urandom_range(499, 0) == 0);
         cyc(1);
      end
      flush = 1'b0; rst = 1'b0; idle();
      cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
